// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared FSM states, RAM opcodes and frame length for the SPI-to-RAM subsystem
package spi_ram_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam int FRAME_LEN = 10;
endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: latches a read byte on load and shifts it out MSB-first on miso
//   clk, rst (sync, active-high), clr (abort), load, data -> miso (registered), busy
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         miso,
  output logic         busy
);
  logic [W-1:0] sr;
  logic [2:0]   cnt;
  // zeros fill in behind the data, so miso falls to 0 once the byte is out
  always_ff @(posedge clk)
    if (rst || clr) begin
      sr   <= '0;
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
    end else if (load) begin
      sr   <= data << 1;
      cnt  <= 3'(W - 1);
      miso <= data[W-1];
      busy <= 1'b1;
    end else begin
      miso <= sr[W-1];
      sr   <= sr << 1;
      cnt  <= busy ? cnt - 3'd1 : cnt;
      busy <= busy && cnt != 3'd0;
    end
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end; deserialises 10-bit RAM commands and serialises read data
//   clk (SCLK), rst (sync, active-high), ss_n, mosi -> rx_data/rx_valid to RAM
//   tx_data/tx_valid from RAM -> miso
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  state_t               st;
  logic [3:0]           cnt;
  logic [ADDR_SIZE+1:0] sr;
  logic                 done;
  logic                 wait_tx;
  logic                 rd_addr_seen;
  logic                 ser_busy;
  logic                 ser_load;
  assign ser_load = wait_tx && tx_valid && !ss_n && !ser_busy;
  spi_tx_serializer #(.W(ADDR_SIZE)) u_ser (
    .clk  (clk),
    .rst  (rst),
    .clr  (ss_n),
    .load (ser_load),
    .data (tx_data),
    .miso (miso),
    .busy (ser_busy)
  );
  // cnt counts the 9 body bits; it parks at FRAME_LEN-1 so later mosi bits are ignored
  always_ff @(posedge clk)
    if (rst) begin
      st           <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      done         <= 1'b0;
      wait_tx      <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= done;
      rx_data  <= done ? sr : rx_data;
      done     <= 1'b0;
      wait_tx  <= !ss_n && ((wait_tx && !ser_load) || (done && st == READ_DATA));
      if (ser_load) rd_addr_seen <= 1'b0;
      if (ss_n) begin
        st  <= IDLE;
        cnt <= '0;
      end else
        case (st)
          IDLE: st <= CHK_CMD;
          CHK_CMD: begin
            sr  <= {sr[ADDR_SIZE:0], mosi};
            cnt <= '0;
            st  <= !mosi ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
          end
          default:
            if (cnt != 4'(FRAME_LEN - 1)) begin
              sr  <= {sr[ADDR_SIZE:0], mosi};
              cnt <= cnt + 4'd1;
              if (cnt == 4'(FRAME_LEN - 2)) begin
                done <= 1'b1;
                if (st == READ_ADD) rd_addr_seen <= 1'b1;
              end
            end
        endcase
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed self-checking bench for spi_slave_if
module tb_spi_slave_if;
  import spi_ram_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [7:0] rd_byte = 8'hA5;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ss_n fall sampled on edge 0, bit 9 on edge 1, bit 0 on edge 10, rx_valid after edge 11
  task automatic send_frame(input logic [9:0] w, input state_t exp_st);
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      mosi = w[i];
      tick();
      if (i == 9) chk("dispatch", 32'(dut.st), 32'(exp_st));
      chk("no_early_valid", 32'(rx_valid), 32'd0);
      chk("miso_quiet", 32'(miso), 32'd0);
    end
    mosi = 1'b1;
    tick();
    chk("rx_valid_hi", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'(w));
    tick();
    chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
    chk("rx_data_hold", 32'(rx_data), 32'(w));
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    chk("idle", 32'(dut.st), 32'(IDLE));
    chk("miso_idle", 32'(miso), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_state", 32'(dut.st), 32'(IDLE));
    chk("rst_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
    rst = 1'b0;
    tick();
    send_frame(10'b0010010110, WRITE);
    end_frame();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    send_frame(10'b0101011011, WRITE);
    chk("wr_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
    tick();
    chk("stray_tx_valid", 32'(miso), 32'd0);
    tx_valid = 1'b0;
    end_frame();
    send_frame(10'b1010101110, READ_ADD);
    chk("rdaddr_seen_set", 32'(dut.rd_addr_seen), 32'd1);
    end_frame();
    send_frame(10'b1101010101, READ_DATA);
    chk("rddata_seen_held", 32'(dut.rd_addr_seen), 32'd1);
    tx_valid = 1'b1;
    tx_data  = rd_byte;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    chk("miso_b7", 32'(miso), 32'd1);
    chk("rd_seen_clr", 32'(dut.rd_addr_seen), 32'd0);
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("miso_bit", 32'(miso), 32'(rd_byte[i]));
    end
    tick();
    chk("miso_after", 32'(miso), 32'd0);
    tick();
    chk("miso_after2", 32'(miso), 32'd0);
    end_frame();
    ss_n = 1'b0;
    tick();
    mosi = 1'b0; tick();
    mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    ss_n = 1'b1;
    tick();
    chk("abort_idle", 32'(dut.st), 32'(IDLE));
    chk("abort_no_valid", 32'(rx_valid), 32'd0);
    tick();
    chk("abort_no_valid2", 32'(rx_valid), 32'd0);
    chk("abort_rx_hold", 32'(rx_data), 32'(10'b1101010101));
    send_frame(10'b0101011011, WRITE);
    end_frame();
    send_frame(10'b1100000001, READ_ADD);
    chk("fake_rd_seen", 32'(dut.rd_addr_seen), 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tick();
    chk("fake_no_miso", 32'(miso), 32'd0);
    tx_valid = 1'b0;
    end_frame();
    send_frame(10'b1111110000, READ_DATA);
    tx_valid = 1'b1;
    tx_data  = rd_byte;
    tick();
    tx_valid = 1'b0;
    chk("rst_case_b7", 32'(miso), 32'd1);
    tick();
    chk("rst_case_b6", 32'(miso), 32'd0);
    tick();
    chk("rst_case_b5", 32'(miso), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_state", 32'(dut.st), 32'(IDLE));
    chk("midrst_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_miso", 32'(miso), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
